// File: rtl/difftest_runahead_pkg.sv
// Shared types and widths for the difftest run-ahead event queue and its sink.
// Entry payload fields are sized for the widest supported PC / checkpoint (64 bits).
package difftest_runahead_pkg;

  localparam int SEQ_W      = 8;
  localparam int DROP_W     = 16;
  localparam int PC_MAX_W   = 64;
  localparam int CKPT_MAX_W = 64;

  typedef struct packed {
    logic [SEQ_W-1:0]      index;
    logic                  branch;
    logic                  may_replay;
    logic [PC_MAX_W-1:0]   pc;
    logic [CKPT_MAX_W-1:0] checkpoint_id;
  } entry_t;

endpackage

// File: rtl/difftest_runahead_event_sink.sv
// Reports each consumed run-ahead event to the difftest framework.
// Compiled to an empty shell for synthesis or when DIFFTEST is not defined.
module difftest_runahead_event_sink
  import difftest_runahead_pkg::*;
(
  input logic       io_clock,
  input logic [7:0] io_coreid,
  input logic       fire,
  input entry_t     head
);

`ifdef DIFFTEST
`ifndef SYNTHESIS
  int unsigned  sink_calls_r = 0;
  logic [7:0]   last_coreid_r;
  logic [7:0]   last_index_r;
  logic         last_valid_r;
  logic         last_branch_r;
  logic         last_may_replay_r;
  logic [63:0]  last_pc_r;
  logic [63:0]  last_checkpoint_id_r;

  function automatic void v_difftest_RunaheadEvent(
    input byte     coreid,
    input byte     index,
    input bit      valid,
    input bit      branch,
    input bit      may_replay,
    input longint  pc,
    input longint  checkpoint_id
  );
    last_coreid_r        = coreid;
    last_index_r         = index;
    last_valid_r         = valid;
    last_branch_r        = branch;
    last_may_replay_r    = may_replay;
    last_pc_r            = pc;
    last_checkpoint_id_r = checkpoint_id;
    sink_calls_r         = sink_calls_r + 32'd1;
  endfunction

  // One sink call per completed pop.
  always @(posedge io_clock) begin
    if (fire) begin
      v_difftest_RunaheadEvent(io_coreid, head.index, 1'b1, head.branch,
                               head.may_replay, head.pc, head.checkpoint_id);
    end
  end
`else
  logic unused_s;
  assign unused_s = ^{io_clock, io_coreid, fire, head};
`endif
`else
  logic unused_s;
  assign unused_s = ^{io_clock, io_coreid, fire, head};
`endif

endmodule

// File: rtl/difftest_runahead_event_queue.sv
// Multi-channel run-ahead event FIFO: compacts up to NUM_CH events per cycle,
// tags them with sequence numbers, tracks drops and checkpoint ordering.
module difftest_runahead_event_queue
  import difftest_runahead_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 8,
  parameter int PC_W   = 64,
  parameter int CKPT_W = 64
) (
  input  logic                       io_clock,
  input  logic                       io_reset,
  input  logic [7:0]                 io_coreid,
  input  logic                       io_flush,
  input  logic [NUM_CH-1:0]          io_in_valid,
  input  logic [NUM_CH-1:0]          io_in_branch,
  input  logic [NUM_CH-1:0]          io_in_may_replay,
  input  logic [NUM_CH*PC_W-1:0]     io_in_pc,
  input  logic [NUM_CH*CKPT_W-1:0]   io_in_checkpoint_id,
  output logic                       io_out_valid,
  input  logic                       io_out_ready,
  output logic [7:0]                 io_out_index,
  output logic                       io_out_branch,
  output logic                       io_out_may_replay,
  output logic [PC_W-1:0]            io_out_pc,
  output logic [CKPT_W-1:0]          io_out_checkpoint_id,
  output logic [$clog2(DEPTH):0]     io_count,
  output logic [DROP_W-1:0]          io_drop_count,
  output logic                       io_overflow,
  output logic                       io_ckpt_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int DSUM_W = DROP_W + 1;

  entry_t             mem_r [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [SEQ_W-1:0]   seq_r;
  logic [DROP_W-1:0]  drop_r;
  logic               overflow_r;
  logic               ckpt_err_r;
  logic               ref_valid_r;
  logic [CKPT_W-1:0]  ref_r;

  logic               pop_s;
  logic [CNT_W-1:0]   free_s;
  logic [NUM_CH-1:0]  acc_s;
  logic [PTR_W-1:0]   slot_s  [NUM_CH];
  entry_t             entry_s [NUM_CH];
  logic [CNT_W-1:0]   acc_cnt_s;
  logic [2:0]         drop_cnt_s;
  logic               ckpt_viol_s;
  logic               ref_valid_s;
  logic [CKPT_W-1:0]  ref_s;
  logic [DSUM_W-1:0]  drop_sum_s;
  logic [DROP_W-1:0]  drop_next_s;
  entry_t             head_s;
  logic               fire_s;

  // Channel compaction, sequence tagging, drop counting and checkpoint ordering.
  always_comb begin
    logic [CNT_W-1:0]  acc_v;
    logic [2:0]        drop_v;
    logic              viol_v;
    logic              refv_v;
    logic [CKPT_W-1:0] ref_v;
    pop_s  = (count_r != {CNT_W{1'b0}}) && io_out_ready;
    free_s = CNT_W'(DEPTH) - count_r + (pop_s ? CNT_W'(1) : CNT_W'(0));
    acc_v  = {CNT_W{1'b0}};
    drop_v = 3'd0;
    viol_v = 1'b0;
    refv_v = ref_valid_r;
    ref_v  = ref_r;
    for (int k = 0; k < NUM_CH; k++) begin
      acc_s[k]                  = 1'b0;
      slot_s[k]                 = wr_ptr_r + acc_v[PTR_W-1:0];
      entry_s[k].index          = seq_r + SEQ_W'(acc_v);
      entry_s[k].branch         = io_in_branch[k];
      entry_s[k].may_replay     = io_in_may_replay[k];
      entry_s[k].pc             = PC_MAX_W'(io_in_pc[k*PC_W +: PC_W]);
      entry_s[k].checkpoint_id  = CKPT_MAX_W'(io_in_checkpoint_id[k*CKPT_W +: CKPT_W]);
      if (io_in_valid[k]) begin
        if (acc_v < free_s) begin
          acc_s[k] = 1'b1;
          acc_v    = acc_v + CNT_W'(1);
          if (io_in_branch[k]) begin
            if (refv_v && (io_in_checkpoint_id[k*CKPT_W +: CKPT_W] <= ref_v)) begin
              viol_v = 1'b1;
            end else begin
              viol_v = viol_v;
            end
            refv_v = 1'b1;
            ref_v  = io_in_checkpoint_id[k*CKPT_W +: CKPT_W];
          end else begin
            refv_v = refv_v;
          end
        end else begin
          drop_v = drop_v + 3'd1;
        end
      end else begin
        acc_v = acc_v;
      end
    end
    acc_cnt_s   = acc_v;
    drop_cnt_s  = drop_v;
    ckpt_viol_s = viol_v;
    ref_valid_s = refv_v;
    ref_s       = ref_v;
    drop_sum_s  = {1'b0, drop_r} + DSUM_W'(drop_cnt_s);
    if (drop_sum_s[DROP_W]) begin
      drop_next_s = {DROP_W{1'b1}};
    end else begin
      drop_next_s = drop_sum_s[DROP_W-1:0];
    end
  end

  // Entry storage; deliberately not reset.
  always_ff @(posedge io_clock) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (acc_s[k] && !io_flush) begin
        mem_r[slot_s[k]] <= entry_s[k];
      end
    end
  end

  // Pointers, occupancy, sequence counter and sticky status.
  always_ff @(posedge io_clock or posedge io_reset) begin
    if (io_reset) begin
      rd_ptr_r    <= {PTR_W{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      seq_r       <= {SEQ_W{1'b0}};
      drop_r      <= {DROP_W{1'b0}};
      overflow_r  <= 1'b0;
      ckpt_err_r  <= 1'b0;
      ref_valid_r <= 1'b0;
      ref_r       <= {CKPT_W{1'b0}};
    end else if (io_flush) begin
      rd_ptr_r    <= {PTR_W{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      ref_valid_r <= 1'b0;
      ref_r       <= {CKPT_W{1'b0}};
    end else begin
      rd_ptr_r    <= rd_ptr_r + {{(PTR_W-1){1'b0}}, pop_s};
      wr_ptr_r    <= wr_ptr_r + acc_cnt_s[PTR_W-1:0];
      count_r     <= count_r + acc_cnt_s - {{(CNT_W-1){1'b0}}, pop_s};
      seq_r       <= seq_r + SEQ_W'(acc_cnt_s);
      drop_r      <= drop_next_s;
      overflow_r  <= overflow_r | (drop_cnt_s != 3'd0);
      ckpt_err_r  <= ckpt_err_r | ckpt_viol_s;
      ref_valid_r <= ref_valid_s;
      ref_r       <= ref_s;
    end
  end

  assign head_s               = mem_r[rd_ptr_r];
  assign io_out_valid         = (count_r != {CNT_W{1'b0}});
  assign io_out_index         = head_s.index;
  assign io_out_branch        = head_s.branch;
  assign io_out_may_replay    = head_s.may_replay;
  assign io_out_pc            = head_s.pc[PC_W-1:0];
  assign io_out_checkpoint_id = head_s.checkpoint_id[CKPT_W-1:0];
  assign io_count             = count_r;
  assign io_drop_count        = drop_r;
  assign io_overflow          = overflow_r;
  assign io_ckpt_err          = ckpt_err_r;

  assign fire_s = pop_s & ~io_flush & ~io_reset;

  difftest_runahead_event_sink u_sink (
    .io_clock  (io_clock),
    .io_coreid (io_coreid),
    .fire      (fire_s),
    .head      (head_s)
  );

endmodule
